// File: rtl/axis_packetizer.sv
// axis_packetizer: collects an AXI-Stream burst from a local source and emits
// header + payload packets to a router local input. Bursts longer than the
// payload cap are split into several packets to the same destination.
module axis_packetizer #(
  parameter int DATA_WIDTH              = 32,
  parameter int MAX_ROUTERS_X           = 4,
  parameter int MAX_ROUTERS_Y           = 4,
  parameter int MAXIMUM_PACKAGES_NUMBER = 5,
  localparam int X_W = $clog2(MAX_ROUTERS_X),
  localparam int Y_W = $clog2(MAX_ROUTERS_Y),
  localparam int C_W = $clog2(MAXIMUM_PACKAGES_NUMBER)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  s_last,
  input  logic [X_W-1:0]        s_dest_x,
  input  logic [Y_W-1:0]        s_dest_y,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last
);

  // Payload cap per packet (header flit excluded) and buffer address width.
  localparam int P   = MAXIMUM_PACKAGES_NUMBER - 1;
  localparam int A_W = (P > 1) ? $clog2(P) : 1;
  localparam logic [C_W-1:0] P_C   = C_W'(P);
  localparam logic [C_W-1:0] ONE_C = C_W'(1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_HEADER  = 2'd2;
  localparam logic [1:0] ST_PAYLOAD = 2'd3;

  logic [1:0]            state_reg, state_next;
  logic [C_W-1:0]        count_reg, count_next;
  logic [C_W-1:0]        rd_ptr_reg, rd_ptr_next;
  logic                  first_beat_reg, first_beat_next;
  logic                  cont_reg, cont_next;
  logic [X_W-1:0]        dest_x_reg, dest_x_next;
  logic [Y_W-1:0]        dest_y_reg, dest_y_next;
  logic                  m_valid_reg, m_valid_next;
  logic                  m_last_reg, m_last_next;
  logic [DATA_WIDTH-1:0] m_data_reg, m_data_next;

  logic [DATA_WIDTH-1:0] buf_mem [P];
  logic                  wr_en;
  logic [A_W-1:0]        wr_idx;

  // Header layout: dest_x in the low bits, then dest_y, then payload count.
  function automatic logic [DATA_WIDTH-1:0] make_header(
    input logic [X_W-1:0] x,
    input logic [Y_W-1:0] y,
    input logic [C_W-1:0] c
  );
    logic [DATA_WIDTH-1:0] hdr;
    hdr = '0;
    hdr[X_W-1:0]             = x;
    hdr[X_W+Y_W-1:X_W]       = y;
    hdr[X_W+Y_W+C_W-1:X_W+Y_W] = c;
    return hdr;
  endfunction

  // Source side is only open while gathering; no overlap with draining.
  assign s_ready = (state_reg == ST_IDLE) || (state_reg == ST_COLLECT);
  assign m_data  = m_data_reg;
  assign m_valid = m_valid_reg;
  assign m_last  = m_last_reg;

  // Next-state logic: collect beats, then present header and payload flits.
  always_comb begin
    state_next      = state_reg;
    count_next      = count_reg;
    rd_ptr_next     = rd_ptr_reg;
    first_beat_next = first_beat_reg;
    cont_next       = cont_reg;
    dest_x_next     = dest_x_reg;
    dest_y_next     = dest_y_reg;
    m_valid_next    = m_valid_reg;
    m_last_next     = m_last_reg;
    m_data_next     = m_data_reg;
    wr_en           = 1'b0;
    wr_idx          = '0;

    case (state_reg)
      ST_IDLE: begin
        if (s_valid) begin
          wr_en      = 1'b1;
          wr_idx     = '0;
          count_next = ONE_C;
          // Continuation packets of a split burst reuse the latched dest.
          if (first_beat_reg) begin
            dest_x_next = s_dest_x;
            dest_y_next = s_dest_y;
          end
          if (s_last || (P == 1)) begin
            state_next   = ST_HEADER;
            cont_next    = !s_last;
            m_valid_next = 1'b1;
            m_last_next  = 1'b0;
            m_data_next  = make_header(dest_x_next, dest_y_next, ONE_C);
          end else begin
            state_next = ST_COLLECT;
          end
        end
      end

      ST_COLLECT: begin
        if (s_valid) begin
          wr_en      = 1'b1;
          wr_idx     = count_reg[A_W-1:0];
          count_next = count_reg + 1'b1;
          if (s_last || (count_next == P_C)) begin
            state_next   = ST_HEADER;
            cont_next    = !s_last;
            m_valid_next = 1'b1;
            m_last_next  = 1'b0;
            m_data_next  = make_header(dest_x_reg, dest_y_reg, count_next);
          end
        end
      end

      ST_HEADER: begin
        if (m_ready) begin
          state_next  = ST_PAYLOAD;
          rd_ptr_next = '0;
          m_data_next = buf_mem[0];
          m_last_next = (count_reg == ONE_C);
        end
      end

      default: begin // ST_PAYLOAD
        if (m_ready) begin
          if (m_last_reg) begin
            state_next      = ST_IDLE;
            m_valid_next    = 1'b0;
            m_last_next     = 1'b0;
            m_data_next     = '0;
            first_beat_next = !cont_reg;
            cont_next       = 1'b0;
            count_next      = '0;
            rd_ptr_next     = '0;
          end else begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
            m_data_next = buf_mem[rd_ptr_next[A_W-1:0]];
            m_last_next = (rd_ptr_next == (count_reg - 1'b1));
          end
        end
      end
    endcase
  end

  // Control and output registers; reset drops any packet in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      count_reg      <= '0;
      rd_ptr_reg     <= '0;
      first_beat_reg <= 1'b1;
      cont_reg       <= 1'b0;
      dest_x_reg     <= '0;
      dest_y_reg     <= '0;
      m_valid_reg    <= 1'b0;
      m_last_reg     <= 1'b0;
      m_data_reg     <= '0;
    end else begin
      state_reg      <= state_next;
      count_reg      <= count_next;
      rd_ptr_reg     <= rd_ptr_next;
      first_beat_reg <= first_beat_next;
      cont_reg       <= cont_next;
      dest_x_reg     <= dest_x_next;
      dest_y_reg     <= dest_y_next;
      m_valid_reg    <= m_valid_next;
      m_last_reg     <= m_last_next;
      m_data_reg     <= m_data_next;
    end
  end

  // Payload buffer write port; contents need no reset since count gates reads.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      buf_mem[wr_idx] <= s_data;
    end
  end

endmodule

// File: tb/tb_axis_packetizer.sv
// Directed testbench for axis_packetizer (default parameters: P = 4,
// header = {count[6:4], y[3:2], x[1:0]}).
module tb_axis_packetizer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        s_last;
  logic [1:0]  s_dest_x;
  logic [1:0]  s_dest_y;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;

  int checks_total  = 0;
  int checks_passed = 0;
  int checks_failed = 0;

  axis_packetizer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_last   (s_last),
    .s_dest_x (s_dest_x),
    .s_dest_y (s_dest_y),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_last   (m_last)
  );

  always #5 clk = ~clk;

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else begin
      checks_failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one source beat and let it be accepted on the next edge.
  task automatic beat(input logic [31:0] d, input logic l, input logic [1:0] x, input logic [1:0] y);
    s_valid  = 1'b1;
    s_data   = d;
    s_last   = l;
    s_dest_x = x;
    s_dest_y = y;
    check("beat_s_ready", 64'(s_ready), 64'd1);
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Check the current output flit and hand it off with m_ready high.
  task automatic expect_flit(input string tag, input logic [31:0] d, input logic l);
    m_ready = 1'b1;
    check({tag, "_valid"}, 64'(m_valid), 64'd1);
    check({tag, "_data"},  64'(m_data),  64'(d));
    check({tag, "_last"},  64'(m_last),  64'(l));
    check({tag, "_sready"}, 64'(s_ready), 64'd0);
    $display("flit %s data=%h last=%0d", tag, m_data, m_last);
    tick();
  endtask

  // Stall the output for n cycles and confirm the flit is held.
  task automatic stall(input string tag, input logic [31:0] d, input logic l, input int n);
    m_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      check({tag, "_hold_valid"}, 64'(m_valid), 64'd1);
      check({tag, "_hold_data"},  64'(m_data),  64'(d));
      check({tag, "_hold_last"},  64'(m_last),  64'(l));
    end
    m_ready = 1'b1;
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "_idle_valid"},  64'(m_valid), 64'd0);
    check({tag, "_idle_sready"}, 64'(s_ready), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; s_data = '0; s_valid = 1'b0; s_last = 1'b0;
    s_dest_x = '0; s_dest_y = '0; m_ready = 1'b1;

    // Reset state
    tick(); tick();
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_last",  64'(m_last),  64'd0);
    check("rst_m_data",  64'(m_data),  64'd0);
    check("rst_s_ready", 64'(s_ready), 64'd1);
    rst_n = 1'b1;
    tick();

    // Single beat to (2,1): header 0x16, then 0xA5 with m_last
    beat(32'hA5, 1'b1, 2'd2, 2'd1);
    expect_flit("single_hdr", 32'h16, 1'b0);
    expect_flit("single_p0",  32'hA5, 1'b1);
    expect_idle("single");

    // Exact fit: 4 beats to (3,3), header count 4 = 0x4F
    beat(32'h1, 1'b0, 2'd3, 2'd3);
    beat(32'h2, 1'b0, 2'd3, 2'd3);
    beat(32'h3, 1'b0, 2'd3, 2'd3);
    beat(32'h4, 1'b1, 2'd3, 2'd3);
    expect_flit("fit_hdr", 32'h4F, 1'b0);
    expect_flit("fit_p0",  32'h1, 1'b0);
    expect_flit("fit_p1",  32'h2, 1'b0);
    expect_flit("fit_p2",  32'h3, 1'b0);
    expect_flit("fit_p3",  32'h4, 1'b1);
    expect_idle("fit");

    // Split: 7 beats to (1,2); dest changed to (0,0) on beats 5..7 is ignored
    beat(32'h11, 1'b0, 2'd1, 2'd2);
    beat(32'h12, 1'b0, 2'd1, 2'd2);
    beat(32'h13, 1'b0, 2'd1, 2'd2);
    beat(32'h14, 1'b0, 2'd1, 2'd2);
    expect_flit("splitA_hdr", 32'h49, 1'b0);
    expect_flit("splitA_p0",  32'h11, 1'b0);
    expect_flit("splitA_p1",  32'h12, 1'b0);
    expect_flit("splitA_p2",  32'h13, 1'b0);
    expect_flit("splitA_p3",  32'h14, 1'b1);
    expect_idle("splitA");
    beat(32'h15, 1'b0, 2'd0, 2'd0);
    beat(32'h16, 1'b0, 2'd0, 2'd0);
    beat(32'h17, 1'b1, 2'd0, 2'd0);
    expect_flit("splitB_hdr", 32'h39, 1'b0);
    expect_flit("splitB_p0",  32'h15, 1'b0);
    expect_flit("splitB_p1",  32'h16, 1'b0);
    expect_flit("splitB_p2",  32'h17, 1'b1);
    expect_idle("splitB");

    // Backpressure: 2 beats to (2,3), header 0x2E; m_ready 1,0,0,1 pattern
    beat(32'h21, 1'b0, 2'd2, 2'd3);
    beat(32'h22, 1'b1, 2'd2, 2'd3);
    check("bp_hdr_data", 64'(m_data), 64'h2E);
    stall("bp_hdr", 32'h2E, 1'b0, 2);
    expect_flit("bp_hdr", 32'h2E, 1'b0);
    stall("bp_p0", 32'h21, 1'b0, 2);
    expect_flit("bp_p0", 32'h21, 1'b0);
    stall("bp_p1", 32'h22, 1'b1, 1);
    expect_flit("bp_p1", 32'h22, 1'b1);
    expect_idle("bp");

    // Reset after 2 of 4 payload flits to (3,0) (header 0x43)
    beat(32'h31, 1'b0, 2'd3, 2'd0);
    beat(32'h32, 1'b0, 2'd3, 2'd0);
    beat(32'h33, 1'b0, 2'd3, 2'd0);
    beat(32'h34, 1'b1, 2'd3, 2'd0);
    expect_flit("rstmid_hdr", 32'h43, 1'b0);
    expect_flit("rstmid_p0",  32'h31, 1'b0);
    expect_flit("rstmid_p1",  32'h32, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rstmid_m_valid", 64'(m_valid), 64'd0);
    check("rstmid_m_last",  64'(m_last),  64'd0);
    check("rstmid_s_ready", 64'(s_ready), 64'd1);
    beat(32'h55, 1'b1, 2'd0, 2'd1);
    expect_flit("postrst_hdr", 32'h14, 1'b0);
    expect_flit("postrst_p0",  32'h55, 1'b1);
    expect_idle("postrst");

    // Back-to-back: burst 1 to (1,1) (header 0x25); burst 2 held valid meanwhile
    beat(32'h61, 1'b0, 2'd1, 2'd1);
    beat(32'h62, 1'b1, 2'd1, 2'd1);
    s_valid = 1'b1; s_data = 32'h71; s_last = 1'b1; s_dest_x = 2'd2; s_dest_y = 2'd2;
    expect_flit("b2b1_hdr", 32'h25, 1'b0);
    expect_flit("b2b1_p0",  32'h61, 1'b0);
    expect_flit("b2b1_p1",  32'h62, 1'b1);
    expect_idle("b2b_gap");
    tick();
    s_valid = 1'b0; s_last = 1'b0;
    expect_flit("b2b2_hdr", 32'h1A, 1'b0);
    expect_flit("b2b2_p0",  32'h71, 1'b1);
    expect_idle("b2b2");

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
